idu_exu_reg: RTL and testbench

//  ID->EX pipeline register directly upstream of the ALU. Captures one decoded instruction from the IDU.

---
 rtl/idu_exu_reg_pkg.sv | 44 ++++
 rtl/idu_exu_reg.sv | 104 ++++++++++
 tb/tb_idu_exu_reg.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/idu_exu_reg_pkg.sv
// Shared widths, ALU opcodes and the stored-entry layout for the ID->EX register.
package idu_exu_reg_pkg;

  localparam int XLEN    = 64;
  localparam int ALUOP_W = 6;
  localparam int RIDX_W  = 5;

  typedef logic [XLEN-1:0]    vec_t;
  typedef logic [ALUOP_W-1:0] aluop_t;
  typedef logic [RIDX_W-1:0]  ridx_t;

  // ALU operation codes driven on alu_op.
  localparam aluop_t ALU_ADD = 6'd0;
  localparam aluop_t ALU_SUB = 6'd1;
  localparam aluop_t ALU_AND = 6'd2;
  localparam aluop_t ALU_OR  = 6'd3;
  localparam aluop_t ALU_XOR = 6'd4;
  localparam aluop_t ALU_SLL = 6'd5;
  localparam aluop_t ALU_SRL = 6'd6;
  localparam aluop_t ALU_SRA = 6'd7;
  localparam aluop_t ALU_SLT = 6'd8;

  // Single-entry occupancy.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Everything the stage holds for one decoded instruction.
  typedef struct packed {
    vec_t   pc;
    vec_t   rs1;
    vec_t   rs2;
    vec_t   imm;
    ridx_t  rs1_idx;
    ridx_t  rs2_idx;
    logic   op1_sel;
    logic   op2_sel;
    aluop_t alu_op;
    ridx_t  rd_idx;
    logic   rd_wen;
  } entry_t;

endpackage

// File: rtl/idu_exu_reg.sv
// ID->EX pipeline register: holds one decoded instruction, selects ALU operands
// and forwards register-file writebacks into the held source values.
module idu_exu_reg
  import idu_exu_reg_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [XLEN-1:0]    in_rs1_data,
  input  logic [XLEN-1:0]    in_rs2_data,
  input  logic [XLEN-1:0]    in_imm,
  input  logic [RIDX_W-1:0]  in_rs1_idx,
  input  logic [RIDX_W-1:0]  in_rs2_idx,
  input  logic               in_op1_sel,
  input  logic               in_op2_sel,
  input  logic [ALUOP_W-1:0] in_alu_op,
  input  logic [RIDX_W-1:0]  in_rd_idx,
  input  logic               in_rd_wen,
  input  logic               wb_wen,
  input  logic [RIDX_W-1:0]  wb_idx,
  input  logic [XLEN-1:0]    wb_data,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [XLEN-1:0]    operator_1,
  output logic [XLEN-1:0]    operator_2,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [XLEN-1:0]    out_rs2_data,
  output logic [RIDX_W-1:0]  out_rd_idx,
  output logic               out_rd_wen
);

  state_e r_state;
  entry_t r_entry;
  entry_t w_cap_entry;
  logic   w_capture;
  logic   w_hold;

  // Forward a same-cycle regfile write into a source value; x0 is never forwarded.
  function automatic vec_t bypass(input ridx_t idx, input vec_t data,
                                  input logic b_wen, input ridx_t b_idx, input vec_t b_data);
    return (b_wen && (b_idx == idx) && (idx != '0)) ? b_data : data;
  endfunction

  assign out_valid = (r_state == ST_FULL);
  // NOTE: in_ready must not look at in_valid, otherwise upstream logic that
  // waits for ready before raising valid forms a combinational loop.
  assign in_ready  = !out_valid || out_ready;
  assign w_capture = in_valid && in_ready && !flush;
  assign w_hold    = out_valid && !out_ready;

  // Assemble the incoming entry, with writeback forwarding on both sources.
  always_comb begin
    w_cap_entry         = '0;
    w_cap_entry.pc      = in_pc;
    w_cap_entry.rs1     = bypass(in_rs1_idx, in_rs1_data, wb_wen, wb_idx, wb_data);
    w_cap_entry.rs2     = bypass(in_rs2_idx, in_rs2_data, wb_wen, wb_idx, wb_data);
    w_cap_entry.imm     = in_imm;
    w_cap_entry.rs1_idx = in_rs1_idx;
    w_cap_entry.rs2_idx = in_rs2_idx;
    w_cap_entry.op1_sel = in_op1_sel;
    w_cap_entry.op2_sel = in_op2_sel;
    w_cap_entry.alu_op  = in_alu_op;
    w_cap_entry.rd_idx  = in_rd_idx;
    w_cap_entry.rd_wen  = in_rd_wen;
  end

  // Occupancy: flush empties, otherwise refill whenever the slot frees up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else if (flush) begin
      r_state <= ST_EMPTY;
    end else if (in_ready) begin
      r_state <= in_valid ? ST_FULL : ST_EMPTY;
    end
  end

  // Entry storage: load on capture, otherwise refresh held sources from writebacks.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the datapath fields are reset too, because every output is
    // required to read 0 while reset is asserted, not just out_valid.
    if (rst) begin
      r_entry <= '0;
    end else if (w_capture) begin
      r_entry <= w_cap_entry;
    end else if (w_hold) begin
      r_entry.rs1 <= bypass(r_entry.rs1_idx, r_entry.rs1, wb_wen, wb_idx, wb_data);
      r_entry.rs2 <= bypass(r_entry.rs2_idx, r_entry.rs2, wb_wen, wb_idx, wb_data);
    end
  end

  assign out_pc       = r_entry.pc;
  assign operator_1   = r_entry.op1_sel ? r_entry.pc  : r_entry.rs1;
  assign operator_2   = r_entry.op2_sel ? r_entry.imm : r_entry.rs2;
  assign alu_op       = r_entry.alu_op;
  assign out_rs2_data = r_entry.rs2;
  assign out_rd_idx   = r_entry.rd_idx;
  assign out_rd_wen   = out_valid && r_entry.rd_wen;

endmodule

// File: tb/tb_idu_exu_reg.sv
// Directed bench for the ID->EX register: reset, operand select, backpressure,
// bypass, flush, back-to-back streaming and asynchronous reset.
module tb_idu_exu_reg;
  import idu_exu_reg_pkg::*;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [XLEN-1:0]    in_pc;
  logic [XLEN-1:0]    in_rs1_data;
  logic [XLEN-1:0]    in_rs2_data;
  logic [XLEN-1:0]    in_imm;
  logic [RIDX_W-1:0]  in_rs1_idx;
  logic [RIDX_W-1:0]  in_rs2_idx;
  logic               in_op1_sel;
  logic               in_op2_sel;
  logic [ALUOP_W-1:0] in_alu_op;
  logic [RIDX_W-1:0]  in_rd_idx;
  logic               in_rd_wen;
  logic               wb_wen;
  logic [RIDX_W-1:0]  wb_idx;
  logic [XLEN-1:0]    wb_data;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_pc;
  logic [XLEN-1:0]    operator_1;
  logic [XLEN-1:0]    operator_2;
  logic [ALUOP_W-1:0] alu_op;
  logic [XLEN-1:0]    out_rs2_data;
  logic [RIDX_W-1:0]  out_rd_idx;
  logic               out_rd_wen;

  int errors = 0;
  int checks = 0;

  idu_exu_reg dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_rs1_data  (in_rs1_data),
    .in_rs2_data  (in_rs2_data),
    .in_imm       (in_imm),
    .in_rs1_idx   (in_rs1_idx),
    .in_rs2_idx   (in_rs2_idx),
    .in_op1_sel   (in_op1_sel),
    .in_op2_sel   (in_op2_sel),
    .in_alu_op    (in_alu_op),
    .in_rd_idx    (in_rd_idx),
    .in_rd_wen    (in_rd_wen),
    .wb_wen       (wb_wen),
    .wb_idx       (wb_idx),
    .wb_data      (wb_data),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .operator_1   (operator_1),
    .operator_2   (operator_2),
    .alu_op       (alu_op),
    .out_rs2_data (out_rs2_data),
    .out_rd_idx   (out_rd_idx),
    .out_rd_wen   (out_rd_wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0; in_imm = '0;
    in_rs1_idx = '0; in_rs2_idx = '0; in_op1_sel = 0; in_op2_sel = 0;
    in_alu_op = '0; in_rd_idx = '0; in_rd_wen = 0;
    wb_wen = 0; wb_idx = '0; wb_data = '0; flush = 0; out_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h want 0", out_valid); end
    checks++; if (operator_1 !== 64'h0) begin errors++; $display("FAIL reset_op1: got %0h want 0", operator_1); end
    checks++; if (operator_2 !== 64'h0) begin errors++; $display("FAIL reset_op2: got %0h want 0", operator_2); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0h want 1", in_ready); end
    checks++; if (out_rd_wen !== 1'b0) begin errors++; $display("FAIL reset_rd_wen: got %0h want 0", out_rd_wen); end
    step();
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid[%0d]: got %0h want 0", i, out_valid); end
    end
  endtask

  task automatic test_operand_select();
    idle_inputs();
    out_ready = 1; in_valid = 1;
    in_pc = 64'h8000_0000; in_imm = 64'h10; in_op1_sel = 1; in_op2_sel = 1;
    in_alu_op = ALU_ADD; in_rs1_data = 64'h1111; in_rs2_data = 64'h2222;
    in_rd_idx = 5'd7; in_rd_wen = 1;
    step();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sel_valid: got %0h want 1", out_valid); end
    checks++; if (operator_1 !== 64'h8000_0000) begin errors++; $display("FAIL sel_op1: got %0h want 80000000", operator_1); end
    checks++; if (operator_2 !== 64'h10) begin errors++; $display("FAIL sel_op2: got %0h want 10", operator_2); end
    checks++; if (alu_op !== ALU_ADD) begin errors++; $display("FAIL sel_aluop: got %0h want %0h", alu_op, ALU_ADD); end
    checks++; if (out_rs2_data !== 64'h2222) begin errors++; $display("FAIL sel_rs2: got %0h want 2222", out_rs2_data); end
    checks++; if (out_rd_idx !== 5'd7) begin errors++; $display("FAIL sel_rd_idx: got %0h want 7", out_rd_idx); end
    checks++; if (out_rd_wen !== 1'b1) begin errors++; $display("FAIL sel_rd_wen: got %0h want 1", out_rd_wen); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sel_drain_valid: got %0h want 0", out_valid); end
    checks++; if (out_rd_wen !== 1'b0) begin errors++; $display("FAIL sel_drain_rd_wen: got %0h want 0", out_rd_wen); end
  endtask

  task automatic test_backpressure();
    idle_inputs();
    in_valid = 1; in_rs1_data = 64'd5; in_rs2_data = 64'd7; in_alu_op = ALU_SUB;
    step();
    in_rs1_data = 64'd9; in_rs2_data = 64'd11; in_alu_op = ALU_XOR;
    for (int i = 0; i < 4; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %0h want 0", i, in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %0h want 1", i, out_valid); end
      checks++; if (operator_1 !== 64'd5) begin errors++; $display("FAIL bp_op1[%0d]: got %0h want 5", i, operator_1); end
      checks++; if (operator_2 !== 64'd7) begin errors++; $display("FAIL bp_op2[%0d]: got %0h want 7", i, operator_2); end
      checks++; if (alu_op !== ALU_SUB) begin errors++; $display("FAIL bp_aluop[%0d]: got %0h want %0h", i, alu_op, ALU_SUB); end
      step();
    end
    out_ready = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %0h want 1", in_ready); end
    step();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_replace_valid: got %0h want 1", out_valid); end
    checks++; if (operator_1 !== 64'd9) begin errors++; $display("FAIL bp_replace_op1: got %0h want 9", operator_1); end
    checks++; if (operator_2 !== 64'd11) begin errors++; $display("FAIL bp_replace_op2: got %0h want b", operator_2); end
    step();
  endtask

  task automatic test_bypass();
    idle_inputs();
    // Capture-time forwarding into rs1.
    in_valid = 1; in_rs1_idx = 5'd3; in_rs1_data = 64'd1; in_rs2_idx = 5'd4; in_rs2_data = 64'd2;
    wb_wen = 1; wb_idx = 5'd3; wb_data = 64'hAA;
    step();
    in_valid = 0;
    checks++; if (operator_1 !== 64'hAA) begin errors++; $display("FAIL byp_cap_op1: got %0h want aa", operator_1); end
    checks++; if (operator_2 !== 64'd2) begin errors++; $display("FAIL byp_cap_op2: got %0h want 2", operator_2); end
    // Hold-time forwarding into rs2.
    wb_idx = 5'd4; wb_data = 64'hBB;
    step();
    wb_wen = 0;
    checks++; if (operator_2 !== 64'hBB) begin errors++; $display("FAIL byp_hold_op2: got %0h want bb", operator_2); end
    checks++; if (operator_1 !== 64'hAA) begin errors++; $display("FAIL byp_hold_op1: got %0h want aa", operator_1); end
    // Replace with x0 sources; a write to x0 must not be forwarded at capture.
    out_ready = 1; in_valid = 1; in_rs1_idx = 5'd0; in_rs1_data = 64'h55; in_rs2_idx = 5'd0; in_rs2_data = 64'h66;
    wb_wen = 1; wb_idx = 5'd0; wb_data = 64'hCC;
    step();
    out_ready = 0; in_valid = 0;
    checks++; if (operator_1 !== 64'h55) begin errors++; $display("FAIL byp_x0_cap_op1: got %0h want 55", operator_1); end
    checks++; if (operator_2 !== 64'h66) begin errors++; $display("FAIL byp_x0_cap_op2: got %0h want 66", operator_2); end
    // Nor while held.
    step();
    wb_wen = 0;
    checks++; if (operator_1 !== 64'h55) begin errors++; $display("FAIL byp_x0_hold_op1: got %0h want 55", operator_1); end
    // Hold forwarding still updates rs2 when operand 2 selects the immediate.
    out_ready = 1; in_valid = 1; in_rs2_idx = 5'd6; in_rs2_data = 64'h77; in_op2_sel = 1; in_imm = 64'h10;
    step();
    out_ready = 0; in_valid = 0;
    wb_wen = 1; wb_idx = 5'd6; wb_data = 64'hDD;
    step();
    wb_wen = 0;
    checks++; if (out_rs2_data !== 64'hDD) begin errors++; $display("FAIL byp_imm_rs2: got %0h want dd", out_rs2_data); end
    checks++; if (operator_2 !== 64'h10) begin errors++; $display("FAIL byp_imm_op2: got %0h want 10", operator_2); end
    out_ready = 1;
    step();
  endtask

  task automatic test_flush();
    idle_inputs();
    in_valid = 1; in_pc = 64'h100; in_rd_wen = 1;
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid: got %0h want 1", out_valid); end
    out_ready = 1; flush = 1; in_pc = 64'h200;
    step();
    flush = 0; in_valid = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %0h want 0", out_valid); end
    checks++; if (out_rd_wen !== 1'b0) begin errors++; $display("FAIL flush_rd_wen: got %0h want 0", out_rd_wen); end
    checks++; if (out_pc !== 64'h100) begin errors++; $display("FAIL flush_not_captured_pc: got %0h want 100", out_pc); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_stay_empty: got %0h want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] pcs [4];
    pcs[0] = 64'h1000; pcs[1] = 64'h1004; pcs[2] = 64'h1008; pcs[3] = 64'h100C;
    idle_inputs();
    out_ready = 1; in_valid = 1; in_op1_sel = 1;
    for (int i = 0; i < 4; i++) begin
      in_pc = pcs[i];
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %0h want 1", i, out_valid); end
      checks++; if (operator_1 !== pcs[i]) begin errors++; $display("FAIL b2b_op1[%0d]: got %0h want %0h", i, operator_1, pcs[i]); end
    end
    in_valid = 0;
    step();
  endtask

  task automatic test_async_reset();
    idle_inputs();
    in_valid = 1; in_pc = 64'h4000; in_rs1_data = 64'h33; in_rd_wen = 1;
    step();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid: got %0h want 1", out_valid); end
    #2;
    rst = 1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %0h want 0", out_valid); end
    checks++; if (out_pc !== 64'h0) begin errors++; $display("FAIL arst_pc: got %0h want 0", out_pc); end
    checks++; if (operator_1 !== 64'h0) begin errors++; $display("FAIL arst_op1: got %0h want 0", operator_1); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready: got %0h want 1", in_ready); end
    step();
    rst = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_operand_select();
    test_backpressure();
    test_bypass();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
